radix8_booth_mult_seq: RTL and testbench

- Iterative radix-8 Booth multiplier: retires one radix-8 digit per cycle, with valid/ready handshakes on input and output.
- Runtime-selectable signed or unsigned mode; width set by parameter N.
- Successor to the single-shot radix-8 multiplier; intended as the multiply stage of the systolic-array processing element, where input and output may stall.

---
 rtl/radix8_booth_pkg.sv | 24 ++
 rtl/radix8_booth_recoder.sv | 38 +++
 rtl/radix8_booth_mult_seq.sv | 120 ++++++++++++
 tb/tb_radix8_booth_mult_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/radix8_booth_pkg.sv
// Shared types for the radix-8 Booth multiplier family.
// State encoding, digit count helper and recoded digit bundle.
package radix8_booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic neg;
    logic sel_1x;
    logic sel_2x;
    logic sel_3x;
    logic sel_4x;
  } digit_t;

  function automatic int num_digits(input int n);
    return (n + 3) / 3;
  endfunction

endpackage

// File: rtl/radix8_booth_recoder.sv
// Radix-8 Booth recoder: 4-bit window {b3i+2,b3i+1,b3i,b3i-1}
// to a sign plus one-hot magnitude select (digit -4..+4).
module radix8_booth_recoder
  import radix8_booth_pkg::*;
(
  input  logic [3:0] win,
  output digit_t     dig
);

  // Window value is -4*w3 + 2*w2 + w1 + w0
  always_comb begin
    dig = '0;
    unique case (win)
      4'b0000, 4'b1111: dig = '0;
      4'b0001, 4'b0010: dig.sel_1x = 1'b1;
      4'b0011, 4'b0100: dig.sel_2x = 1'b1;
      4'b0101, 4'b0110: dig.sel_3x = 1'b1;
      4'b0111:          dig.sel_4x = 1'b1;
      4'b1000: begin
        dig.neg    = 1'b1;
        dig.sel_4x = 1'b1;
      end
      4'b1001, 4'b1010: begin
        dig.neg    = 1'b1;
        dig.sel_3x = 1'b1;
      end
      4'b1011, 4'b1100: begin
        dig.neg    = 1'b1;
        dig.sel_2x = 1'b1;
      end
      4'b1101, 4'b1110: begin
        dig.neg    = 1'b1;
        dig.sel_1x = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/radix8_booth_mult_seq.sv
// Iterative radix-8 Booth multiplier, one digit per cycle,
// signed/unsigned at runtime, valid/ready on both sides.
module radix8_booth_mult_seq
  import radix8_booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           signed_mode,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] P
);

  localparam int D  = num_digits(N);
  localparam int W  = 2 * N + 4;
  localparam int BW = 3 * D + 1;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  state_t        state;
  logic [W-1:0]  ax;
  logic [W-1:0]  a3;
  logic [W-1:0]  acc;
  logic [BW-1:0] bw;
  logic [IW-1:0] idx;

  logic          ext_a;
  logic          ext_b;
  logic [W-1:0]  a_ext;
  logic [BW-1:0] b_ext;
  digit_t        dig;
  logic [W-1:0]  mag;
  logic [W-1:0]  addend;
  logic [W-1:0]  acc_nx;

  // Mode decides sign or zero fill; B gets the implicit 0 below its LSB
  assign ext_a = signed_mode & A[N-1];
  assign ext_b = signed_mode & B[N-1];
  assign a_ext = {{(W - N){ext_a}}, A};
  assign b_ext = {{(BW - 1 - N){ext_b}}, B, 1'b0};

  assign in_ready = (state == IDLE) & ~reset;

  // Lowest window of the right-shifting multiplier register
  radix8_booth_recoder u_rec (
    .win (bw[3:0]),
    .dig (dig)
  );

  // Pick the pre-shifted multiple selected by the current digit
  always_comb begin
    mag = '0;
    unique case (1'b1)
      dig.sel_1x: mag = ax;
      dig.sel_2x: mag = ax << 1;
      dig.sel_3x: mag = a3;
      dig.sel_4x: mag = ax << 2;
      default:    mag = '0;
    endcase
  end

  assign addend = dig.neg ? (~mag + W'(1)) : mag;
  assign acc_nx = acc + addend;

  // Control FSM; multiples shift left 3 per digit instead of a barrel shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ax        <= '0;
      a3        <= '0;
      acc       <= '0;
      bw        <= '0;
      idx       <= '0;
      P         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ax    <= a_ext;
            bw    <= b_ext;
            state <= PRE;
          end
        end
        PRE: begin
          a3    <= ax + (ax << 1);
          acc   <= '0;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          acc <= acc_nx;
          ax  <= ax << 3;
          a3  <= a3 << 3;
          bw  <= bw >> 3;
          idx <= idx + IW'(1);
          if (idx == LAST) begin
            P         <= acc_nx[2*N-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radix8_booth_mult_seq.sv
// Bench for radix8_booth_mult_seq: directed N=6 cases plus
// randomized N=8 / N=16 traffic against an arithmetic model.
module tb_radix8_booth_mult_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        iv6, ir6, sm6, ov6, or6;
  logic [5:0]  a6, b6;
  logic [11:0] p6;
  logic        iv8, ir8, sm8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv16, ir16, sm16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  radix8_booth_mult_seq #(.N(6)) u6 (
    .clk(clk), .reset(reset), .in_valid(iv6), .in_ready(ir6),
    .signed_mode(sm6), .A(a6), .B(b6), .out_valid(ov6),
    .out_ready(or6), .P(p6)
  );
  radix8_booth_mult_seq #(.N(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .signed_mode(sm8), .A(a8), .B(b8), .out_valid(ov8),
    .out_ready(or8), .P(p8)
  );
  radix8_booth_mult_seq #(.N(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
    .signed_mode(sm16), .A(a16), .B(b16), .out_valid(ov16),
    .out_ready(or16), .P(p16)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Plain integer product of the mode-interpreted operands, mod 2^(2n)
  function automatic logic [63:0] ref_mul(input int n, input bit sm,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, mask;
    mask = (longint'(1) << n) - 1;
    x = longint'({32'd0, a}) & mask;
    y = longint'({32'd0, b}) & mask;
    if (sm && a[n-1]) x = x - (longint'(1) << n);
    if (sm && b[n-1]) y = y - (longint'(1) << n);
    return 64'(x * y) & ((64'd1 << (2 * n)) - 64'd1);
  endfunction

  // Issue one N=6 operation and wait for out_valid (left un-acked)
  task automatic run6(input string tag, input bit sm, input logic [5:0] a,
                      input logic [5:0] b, input logic [11:0] exp);
    int n;
    @(negedge clk);
    sm6 = sm; a6 = a; b6 = b; iv6 = 1'b1;
    n = 0;
    while (!ir6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 64'(ir6), 64'd1);
    @(negedge clk);
    iv6 = 1'b0;
    n = 1;
    while (!ov6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd5);
    check({tag, "_p"}, 64'(p6), 64'(exp));
    check({tag, "_ref"}, 64'(p6), ref_mul(6, sm, 32'(a), 32'(b)));
  endtask

  task automatic ack6(input string tag);
    @(negedge clk);
    or6 = 1'b1;
    @(negedge clk);
    or6 = 1'b0;
    check({tag, "_ovlow"}, 64'(ov6), 64'd0);
    check({tag, "_idle"}, 64'(ir6), 64'd1);
  endtask

  logic [63:0] q8[$];
  logic [63:0] q16[$];
  int          sent, got, n;
  bit          seen;

  initial begin
    iv6 = 0; sm6 = 0; a6 = '0; b6 = '0; or6 = 0;
    iv8 = 0; sm8 = 0; a8 = '0; b8 = '0; or8 = 0;
    iv16 = 0; sm16 = 0; a16 = '0; b16 = '0; or16 = 0;
    reset = 1'b1;
    #12;
    check("rst_ready", 64'(ir6), 64'd0);
    check("rst_valid", 64'(ov6), 64'd0);
    check("rst_p", 64'(p6), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_ready", 64'(ir6), 64'd1);

    run6("s_m13x25", 1'b1, 6'h33, 6'd25, 12'hEBB);
    ack6("s_m13x25");
    run6("u_63x63", 1'b0, 6'h3F, 6'h3F, 12'hF81);
    ack6("u_63x63");
    run6("s_m1xm1", 1'b1, 6'h3F, 6'h3F, 12'h001);
    ack6("s_m1xm1");
    run6("s_m32sq", 1'b1, 6'h20, 6'h20, 12'h400);
    ack6("s_m32sq");
    run6("s_0x25", 1'b1, 6'h00, 6'd25, 12'h000);
    ack6("s_0x25");

    // Backpressure: result held while new operands are offered
    run6("bp", 1'b1, 6'h33, 6'd25, 12'hEBB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv6 = 1'b1; sm6 = 1'b0; a6 = 6'd7; b6 = 6'd3;
      #1;
      check("bp_p", 64'(p6), 64'hEBB);
      check("bp_ov", 64'(ov6), 64'd1);
      check("bp_ir", 64'(ir6), 64'd0);
    end
    @(negedge clk);
    iv6 = 1'b0;
    or6 = 1'b1;
    @(negedge clk);
    or6 = 1'b0;
    check("bp_release_ov", 64'(ov6), 64'd0);
    check("bp_release_ir", 64'(ir6), 64'd1);
    run6("s_31xm1", 1'b1, 6'd31, 6'h3F, 12'hFE1);
    ack6("s_31xm1");

    // Reset pulse during the second RUN cycle
    @(negedge clk);
    sm6 = 1'b1; a6 = 6'h36; b6 = 6'd25; iv6 = 1'b1;
    @(negedge clk);
    iv6 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_ov", 64'(ov6), 64'd0);
    check("midrst_p", 64'(p6), 64'd0);
    check("midrst_ir", 64'(ir6), 64'd0);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov6) seen = 1'b1;
    end
    check("midrst_noout", 64'(seen), 64'd0);
    run6("s_m10x25", 1'b1, 6'h36, 6'd25, 12'hF06);
    ack6("s_m10x25");

    // Randomized back-to-back traffic with random output stalls
    sent = 0;
    got  = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      iv8  = (c < 2600) ? 1'($urandom) : 1'b0;
      sm8  = 1'($urandom);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      or8  = (c < 2600) ? 1'($urandom) : 1'b1;
      iv16 = (c < 2600) ? 1'($urandom) : 1'b0;
      sm16 = 1'($urandom);
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      or16 = (c < 2600) ? 1'($urandom) : 1'b1;
      if (c % 50 == 0) begin
        a8 = 8'h80; b8 = 8'h80; a16 = 16'hFFFF; b16 = 16'hFFFF;
      end
      #1;
      if (iv8 && ir8) begin
        q8.push_back(ref_mul(8, sm8, 32'(a8), 32'(b8)));
        sent++;
      end
      if (iv16 && ir16) begin
        q16.push_back(ref_mul(16, sm16, 32'(a16), 32'(b16)));
        sent++;
      end
      if (ov8 && or8) begin
        got++;
        if (q8.size() == 0) check("r8_extra", 64'd1, 64'd0);
        else check("r8_p", 64'(p8), q8.pop_front());
      end
      if (ov16 && or16) begin
        got++;
        if (q16.size() == 0) check("r16_extra", 64'd1, 64'd0);
        else check("r16_p", 64'(p16), q16.pop_front());
      end
    end
    n = q8.size() + q16.size();
    check("rand_left", 64'(n), 64'd0);
    check("rand_count", 64'(got), 64'(sent));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
